// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences datapath loads/stores onto a word-wide
// synchronous RAM. Sub-word stores are done as read-modify-write.
// Optional build macro: MISALIGN_TRAP_EN traps misaligned half/word accesses.
module mem_access_ctrl #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        addr_err
);

  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          we_q;
  logic          sgn_q;
  logic [1:0]    size_q;
  logic          accept;
  logic          rd_last;
  logic          misalign;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   merged;
  logic [31:0]   extracted;

  assign accept  = req_valid && (state_q == IDLE);
  assign rd_last = (state_q == RD) && (cnt_q == CW'(1));

`ifdef MISALIGN_TRAP_EN
  logic err_q;
  // Halfword needs addr[0]==0, word needs addr[1:0]==0
  assign misalign = (req_size == 2'b01) ? req_addr[0]
                                        : (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (misalign)                   state_d = RESP;
          else if (req_we && req_size[1]) state_d = WR;
          else                            state_d = RD;
        end
      end
      RD:      if (cnt_q == CW'(1)) state_d = we_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Little-endian lane extraction for loads and lane merge for sub-word stores
  always_comb begin
    byte_sel  = mem_rdata[7:0];
    half_sel  = mem_rdata[15:0];
    merged    = mem_rdata;
    extracted = mem_rdata;
    case (addr_q[1:0])
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    if (addr_q[1]) half_sel = mem_rdata[31:16];
    if (size_q == 2'b00) begin
      case (addr_q[1:0])
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
      extracted = {{24{sgn_q & byte_sel[7]}}, byte_sel};
    end else if (size_q == 2'b01) begin
      if (addr_q[1]) merged[31:16] = wdata_q[15:0];
      else           merged[15:0]  = wdata_q[15:0];
      extracted = {{16{sgn_q & half_sel[15]}}, half_sel};
    end
  end

  // Request latches, RD down-counter and captured read data
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      size_q  <= 2'b00;
    end else if (accept) begin
      cnt_q   <= CW'(MEM_LAT);
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      rdata_q <= '0;
      we_q    <= req_we;
      sgn_q   <= req_signed;
      size_q  <= req_size;
    end else if (state_q == RD) begin
      cnt_q <= cnt_q - CW'(1);
      if (rd_last) begin
        if (we_q) wdata_q <= merged;
        else      rdata_q <= extracted;
      end
    end
  end

`ifdef MISALIGN_TRAP_EN
  // Remember the trap decision alongside the request
  always_ff @(posedge clk) begin
    if (reset)       err_q <= 1'b0;
    else if (accept) err_q <= misalign;
  end
`endif

  // Outputs decoded from state and latches
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    mem_we    = (state_q == WR);
    mem_addr  = {addr_q[31:2], 2'b00};
    mem_wdata = wdata_q;
    rsp_rdata = (state_q == RESP) ? rdata_q : 32'd0;
`ifdef MISALIGN_TRAP_EN
    addr_err  = (state_q == RESP) && err_q;
`else
    addr_err  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Testbench for mem_access_ctrl: two instances (MEM_LAT 1 and 3) driven with
// identical transactions, each against its own RAM model.
module tb_mem_access_ctrl;

  localparam int ND   = 2;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid  [ND];
  logic        req_we     [ND];
  logic        req_signed [ND];
  logic [1:0]  req_size   [ND];
  logic [31:0] req_addr   [ND];
  logic [31:0] req_wdata  [ND];
  logic        req_ready  [ND];
  logic        rsp_valid  [ND];
  logic        mem_we     [ND];
  logic        addr_err   [ND];
  logic [31:0] rsp_rdata  [ND];
  logic [31:0] mem_addr   [ND];
  logic [31:0] mem_wdata  [ND];
  logic [31:0] mem_rdata  [ND];

  always #5 clk = ~clk;

  mem_access_ctrl #(.MEM_LAT(LAT0)) u_lat1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_size(req_size[0]), .req_signed(req_signed[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]),
    .rsp_rdata(rsp_rdata[0]), .mem_addr(mem_addr[0]), .mem_we(mem_we[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .addr_err(addr_err[0]));

  mem_access_ctrl #(.MEM_LAT(LAT1)) u_lat3 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_size(req_size[1]), .req_signed(req_signed[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]),
    .rsp_rdata(rsp_rdata[1]), .mem_addr(mem_addr[1]), .mem_we(mem_we[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .addr_err(addr_err[1]));

  // RAMs: one per instance, plus a preload port; instance 1 reads through 2 extra stages
  logic [31:0] ram [ND][256];
  logic        pl_we;
  logic [7:0]  pl_idx;
  logic [31:0] pl_data;
  logic [31:0] rd_p1, rd_p2;

  always_ff @(posedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (pl_we)          ram[d][pl_idx] <= pl_data;
      else if (mem_we[d]) ram[d][mem_addr[d][9:2]] <= mem_wdata[d];
    end
    rd_p1 <= ram[1][mem_addr[1][9:2]];
    rd_p2 <= rd_p1;
  end

  assign mem_rdata[0] = ram[0][mem_addr[0][9:2]];
  assign mem_rdata[1] = rd_p2;

  // Reference memory contents
  logic [31:0] mdl [256];
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic        wr;
    logic [31:0] wword;
    int          lat0;
    int          lat1;
  } vec_t;

  vec_t vt [15];

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic err, input logic wr,
                              input logic [31:0] wword, input int l0, input int l1);
    vec_t v;
    v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.err = err; v.wr = wr; v.wword = wword; v.lat0 = l0; v.lat1 = l1;
    return v;
  endfunction

  task automatic chk(input string name, input string what, input int d,
                     input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s dut%0d: got %h want %h", name, what, d, act, exp);
    end
  endtask

  // Expected result of one request, from the access rules alone
  task automatic model(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic err, output logic wr,
                       output logic [31:0] ww, output int l0, output int l1);
    int nb, off;
    logic [31:0] word, mask, val;
    word = mdl[addr[9:2]];
    nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off  = (nb == 4) ? 0 : (int'(addr[1:0]) & ~(nb - 1));
    err  = TRAP && ((nb == 2 && addr[0]) || (nb == 4 && addr[1:0] != 2'd0));
    rd = 32'd0; wr = 1'b0; ww = 32'd0;
    if (err) begin
      l0 = 1; l1 = 1;
    end else if (!we) begin
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
      val  = (word >> (8 * off)) & mask;
      if (sgn && nb < 4 && val[8 * nb - 1]) val = val | ~mask;
      rd = val; l0 = LAT0 + 1; l1 = LAT1 + 1;
    end else if (nb == 4) begin
      wr = 1'b1; ww = wdata; l0 = 2; l1 = 2;
    end else begin
      mask = ((32'd1 << (8 * nb)) - 32'd1) << (8 * off);
      ww = (word & ~mask) | ((wdata << (8 * off)) & mask);
      wr = 1'b1; l0 = LAT0 + 2; l1 = LAT1 + 2;
    end
  endtask

  task automatic chk_idle_out(input string nm);
    for (int d = 0; d < ND; d++) begin
      chk(nm, "req_ready", d, 32'(req_ready[d]), 32'd1);
      chk(nm, "rsp_valid", d, 32'(rsp_valid[d]), 32'd0);
      chk(nm, "rsp_rdata", d, rsp_rdata[d], 32'd0);
      chk(nm, "mem_addr",  d, mem_addr[d], 32'd0);
      chk(nm, "mem_we",    d, 32'(mem_we[d]), 32'd0);
      chk(nm, "mem_wdata", d, mem_wdata[d], 32'd0);
      chk(nm, "addr_err",  d, 32'(addr_err[d]), 32'd0);
    end
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata);
    for (int d = 0; d < ND; d++) begin
      req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = size;
      req_signed[d] = sgn; req_addr[d] = addr; req_wdata[d] = wdata;
    end
  endtask

  // One request on both instances; scrambles inputs while busy
  task automatic run_txn(input string name, input logic we, input logic [1:0] size,
                         input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] erd, input logic eerr, input logic ewr,
                         input logic [31:0] eww, input int el0, input int el1);
    int lat [ND];
    int wc [ND];
    logic [31:0] rd [ND];
    logic [31:0] ww [ND];
    logic [31:0] wa [ND];
    logic er [ND];
    bit qbad [ND];
    bit rbad [ND];
    bit done [ND];
    int elat [ND];
    elat[0] = el0; elat[1] = el1;
    for (int d = 0; d < ND; d++) begin
      lat[d] = -1; wc[d] = 0; rd[d] = '0; ww[d] = '0; wa[d] = '0; er[d] = 1'b0;
      qbad[d] = 1'b0; rbad[d] = 1'b0; done[d] = 1'b0;
    end
    @(negedge clk);
    drive_req(we, size, sgn, addr, wdata);
    @(posedge clk);
    for (int k = 1; k <= 16 && !(done[0] && done[1]); k++) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
        if (!done[d]) begin
          if (mem_we[d]) begin wc[d]++; ww[d] = mem_wdata[d]; wa[d] = mem_addr[d]; end
          if (req_ready[d]) rbad[d] = 1'b1;
          if (rsp_valid[d]) begin
            done[d] = 1'b1; lat[d] = k; rd[d] = rsp_rdata[d]; er[d] = addr_err[d];
          end else if (rsp_rdata[d] != 32'd0 || addr_err[d]) begin
            qbad[d] = 1'b1;
          end
        end
        if (done[d]) req_valid[d] = 1'b0;
        else begin
          req_valid[d]  = 1'($urandom_range(0, 1));
          req_we[d]     = 1'($urandom_range(0, 1));
          req_size[d]   = 2'($urandom_range(0, 3));
          req_signed[d] = 1'($urandom_range(0, 1));
          req_addr[d]   = $urandom();
          req_wdata[d]  = $urandom();
        end
      end
    end
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk(name, "latency",   d, 32'(lat[d]), 32'(elat[d]));
      chk(name, "rsp_rdata", d, rd[d], erd);
      chk(name, "addr_err",  d, 32'(er[d]), 32'(eerr));
      chk(name, "we_count",  d, 32'(wc[d]), 32'(ewr));
      if (ewr) begin
        chk(name, "wr_word", d, ww[d], eww);
        chk(name, "wr_addr", d, wa[d], {addr[31:2], 2'b00});
      end
      chk(name, "quiet_out", d, 32'(qbad[d]), 32'd0);
      chk(name, "ready_low", d, 32'(rbad[d]), 32'd0);
      chk(name, "ready_after", d, 32'(req_ready[d]), 32'd1);
    end
    if (ewr) mdl[addr[9:2]] = eww;
  endtask

  // Watch a few idle cycles for any stray write strobe or response
  task automatic watch_quiet(input string nm);
    int bad [ND];
    for (int d = 0; d < ND; d++) bad[d] = 0;
    repeat (6) begin
      @(negedge clk);
      for (int d = 0; d < ND; d++) if (mem_we[d] || rsp_valid[d]) bad[d]++;
    end
    for (int d = 0; d < ND; d++) chk(nm, "stray", d, 32'(bad[d]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] erd, eww, w;
    logic eerr, ewr, we, sgn;
    logic [1:0] size;
    logic [31:0] addr, wdata;
    int el0, el1;

    reset = 1'b1;
    pl_we = 1'b0; pl_idx = '0; pl_data = '0;
    for (int d = 0; d < ND; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'b00;
      req_signed[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
    end

    // Preload words 0..31 while held in reset
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      w = (i == 4) ? 32'h8899_AABB : $urandom();
      pl_we = 1'b1; pl_idx = 8'(i); pl_data = w; mdl[i] = w;
    end
    @(negedge clk);
    pl_we = 1'b0;
    @(negedge clk);
    chk_idle_out("reset");
    reset = 1'b0;

    // Directed vectors; RAM word 0x10 starts as 0x8899AABB
    vt[0]  = mk(0, 2'd0, 1, 32'h11, 32'h0,         32'hFFFF_FFAA, 0, 0, 0,             2, 4);
    vt[1]  = mk(0, 2'd1, 0, 32'h12, 32'h0,         32'h0000_8899, 0, 0, 0,             2, 4);
    vt[2]  = mk(0, 2'd1, 1, 32'h12, 32'h0,         32'hFFFF_8899, 0, 0, 0,             2, 4);
    vt[3]  = mk(0, 2'd0, 0, 32'h10, 32'h0,         32'h0000_00BB, 0, 0, 0,             2, 4);
    vt[4]  = mk(0, 2'd2, 0, 32'h10, 32'h0,         32'h8899_AABB, 0, 0, 0,             2, 4);
    vt[5]  = mk(1, 2'd0, 0, 32'h13, 32'h1234_565A, 32'h0,         0, 1, 32'h5A99_AABB, 3, 5);
    vt[6]  = mk(0, 2'd2, 0, 32'h10, 32'h0,         32'h5A99_AABB, 0, 0, 0,             2, 4);
    vt[7]  = mk(1, 2'd2, 0, 32'h20, 32'hDEAD_BEEF, 32'h0,         0, 1, 32'hDEAD_BEEF, 2, 2);
    vt[8]  = mk(0, 2'd2, 0, 32'h20, 32'h0,         32'hDEAD_BEEF, 0, 0, 0,             2, 4);
    vt[9]  = mk(1, 2'd1, 0, 32'h22, 32'hFFFF_1234, 32'h0,         0, 1, 32'h1234_BEEF, 3, 5);
    vt[11] = mk(1, 2'd3, 0, 32'h30, 32'hCAFE_F00D, 32'h0,         0, 1, 32'hCAFE_F00D, 2, 2);
    vt[13] = mk(0, 2'd0, 1, 32'h33, 32'h0,         32'hFFFF_FFCA, 0, 0, 0,             2, 4);
`ifdef MISALIGN_TRAP_EN
    vt[10] = mk(0, 2'd2, 0, 32'h22, 32'h0,         32'h0,         1, 0, 0,             1, 1);
    vt[12] = mk(0, 2'd1, 1, 32'h31, 32'h0,         32'h0,         1, 0, 0,             1, 1);
    vt[14] = mk(1, 2'd1, 0, 32'h21, 32'h0000_7777, 32'h0,         1, 0, 0,             1, 1);
`else
    vt[10] = mk(0, 2'd2, 0, 32'h22, 32'h0,         32'h1234_BEEF, 0, 0, 0,             2, 4);
    vt[12] = mk(0, 2'd1, 1, 32'h31, 32'h0,         32'hFFFF_F00D, 0, 0, 0,             2, 4);
    vt[14] = mk(1, 2'd1, 0, 32'h21, 32'h0000_7777, 32'h0,         0, 1, 32'h1234_7777, 3, 5);
`endif
    for (int i = 0; i < 15; i++) begin
      run_txn($sformatf("vec%0d", i), vt[i].we, vt[i].size, vt[i].sgn, vt[i].addr,
              vt[i].wdata, vt[i].rdata, vt[i].err, vt[i].wr, vt[i].wword,
              vt[i].lat0, vt[i].lat1);
    end

    // Randomized requests against the reference model
    for (int i = 0; i < 150; i++) begin
      we    = 1'($urandom_range(0, 1));
      size  = 2'($urandom_range(0, 3));
      sgn   = 1'($urandom_range(0, 1));
      addr  = $urandom() & 32'hFFFF_FC7F;
      wdata = $urandom();
      model(we, size, sgn, addr, wdata, erd, eerr, ewr, eww, el0, el1);
      run_txn($sformatf("rnd%0d", i), we, size, sgn, addr, wdata, erd, eerr, ewr, eww, el0, el1);
    end

    // Reset during RD of a byte store: request dropped, nothing written
    @(negedge clk);
    drive_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_00EE);
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      req_valid[d] = 1'b0;
      chk("rst_rd", "in_rd_we", d, 32'(mem_we[d]), 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk_idle_out("rst_rd");
    reset = 1'b0;
    watch_quiet("rst_rd");
    for (int d = 0; d < ND; d++) chk("rst_rd", "ram_word", d, ram[d][4], mdl[4]);

    // Reset coincident with WR of a word store: that write lands, nothing after
    @(negedge clk);
    drive_req(1'b1, 2'd2, 1'b0, 32'h40, 32'h7766_5544);
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      req_valid[d] = 1'b0;
      chk("rst_wr", "in_wr_we", d, 32'(mem_we[d]), 32'd1);
    end
    reset = 1'b1;
    @(negedge clk);
    chk_idle_out("rst_wr");
    reset = 1'b0;
    mdl[16] = 32'h7766_5544;
    watch_quiet("rst_wr");
    for (int d = 0; d < ND; d++) chk("rst_wr", "ram_word", d, ram[d][16], mdl[16]);

    // Normal operation resumes after reset
    run_txn("after_rst", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h7766_5544, 1'b0, 1'b0, 32'h0,
            LAT0 + 1, LAT1 + 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter MEM_LAT, default 1, memory read latency in cycles; legal range 1..4.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  datapath presents a memory request.
REQ-005 req_ready  output  1  block can accept a request; high only in IDLE.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word; 11 treated as word.
REQ-008 req_signed  input  1  loads: 1 = sign-extend, 0 = zero-extend.
REQ-009 req_addr  input  32  byte address from the address-source mux.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  32  extended load data; 0 for stores.
REQ-013 mem_addr  output  32  word-aligned address {addr[31:2],2'b00} to synchronous RAM.
REQ-014 mem_we  output  1  full-word write strobe to RAM.
REQ-015 mem_wdata  output  32  full word written to RAM.
REQ-016 mem_rdata  input  32  RAM read data, valid MEM_LAT cycles after mem_addr is driven.
REQ-017 addr_err  output  1  misaligned-access flag, qualified by rsp_valid.

Function
REQ-018 States SHALL be IDLE, RD, WR, RESP; a request is accepted on an edge where req_valid and req_ready are both high (edge T), latching addr, we, size, signed and wdata.
REQ-019 Load: IDLE->RD; RD held exactly MEM_LAT cycles via down-counter; mem_rdata captured on the last RD edge; ->RESP; rsp_valid high in cycle T+MEM_LAT+1.
REQ-020 Word store: IDLE->WR (mem_we=1 exactly one cycle, mem_wdata=latched wdata)->RESP; rsp_valid high in cycle T+2.
REQ-021 Byte/halfword store: IDLE->RD (MEM_LAT cycles)->WR with read word merged (target lane replaced, other lanes preserved)->RESP; rsp_valid in cycle T+MEM_LAT+2.
REQ-022 Little-endian lanes: byte lane = addr[1:0], bits [8k+7:8k]; halfword lane = addr[1], bits [16h+15:16h].
REQ-023 Load extraction: selected byte/half right-justified, bit 7/15 replicated when signed, else zeros; word passed unchanged.
REQ-024 RESP lasts one cycle then ->IDLE; req_ready rises in the cycle after RESP; back-to-back requests therefore have one RESP and one IDLE cycle between them.
REQ-025 mem_addr held constant from T+1 until return to IDLE; mem_we low in all states but WR.
REQ-026 req_valid and request fields ignored outside IDLE; in-flight request never altered.
REQ-027 rsp_rdata and addr_err valid only while rsp_valid; 0 otherwise.

Reset
REQ-028 reset high at an edge SHALL force IDLE, clear counter and latches; outputs: req_ready 1, rsp_valid 0, rsp_rdata 0, mem_addr 0, mem_we 0, mem_wdata 0, addr_err 0.
REQ-029 Reset mid-operation SHALL drop the pending request with no rsp_valid and no further mem_we; a WR cycle coincident with reset still writes (strobe combinational on state), none thereafter.

Configuration
REQ-030 Macro MISALIGN_TRAP_EN: when defined, halfword with addr[0]=1 or word with addr[1:0]!=00 SHALL go IDLE->RESP directly, no RAM access, rsp_rdata 0, addr_err 1 with rsp_valid (cycle T+1).
REQ-031 Without MISALIGN_TRAP_EN: addr_err tied 0; halfword uses addr[1] only, word ignores addr[1:0]; access proceeds normally.

Verification
REQ-032 MEM_LAT=1, RAM[0x10]=0x8899AABB, load byte signed addr 0x11 -> rsp_valid at T+2, rsp_rdata 0xFFFFFFAA.
REQ-033 Same RAM, load half unsigned addr 0x12 -> rsp_rdata 0x00008899; signed -> 0xFFFF8899.
REQ-034 Store byte 0x5A addr 0x13 over 0x8899AABB -> single mem_we cycle, mem_wdata 0x5A99AABB, rsp_valid T+3.
REQ-035 MEM_LAT=3, word store then word load addr 0x20 data 0xDEADBEEF -> rsp_valid T+2 then T+4, readback 0xDEADBEEF, req_ready low throughout.
REQ-036 Reset asserted during RD of a byte store -> no mem_we, no rsp_valid, req_ready 1 next cycle.
REQ-037 MISALIGN_TRAP_EN defined, word load addr 0x22 -> rsp_valid T+1, addr_err 1, mem_we 0, no RD cycle; undefined -> loads word at 0x20, addr_err 0.
